// File: rtl/serial_parity_rx_pkg.sv
// Shared constants for the parity-protected serial link (receiver and transmitter).
package serial_parity_rx_pkg;

    // FSM state encodings, shared with the transmitter
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_DATA      = 3'd1;
    localparam logic [2:0] ST_PARITY    = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Frame delimiters as seen on the line
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bit counter width; covers DATA_W up to 16
    localparam int CNT_W = 5;

    // Parity check: data ^ parity bit ^ odd-select must be zero
    function automatic logic parity_fail(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/serial_parity_rx_if.sv
// Line-side and word-side signals of the serial parity receiver.
interface serial_parity_rx_if #(
    parameter int DATA_W = 8
);
    logic              bit_en;
    logic              sin;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_en, sin,
        input  rx_data, rx_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  bit_en, sin,
        output rx_data, rx_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_parity_rx_parity_acc.sv
// parity_acc: 1-bit running XOR with synchronous clear and enable.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    // Clear has priority over accumulate
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Bit-serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | line idle, waiting for a start bit sample of 0
// ST_DATA      | shifting data bits in, LSB first
// ST_PARITY    | sampling the parity bit into the running XOR
// ST_STOP      | sampling the stop bit; good -> word out, bad -> error
// ST_WAIT_HIGH | after a framing error, wait for the line to return high
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input logic           clk,
    input logic           rst,
    serial_parity_rx_if.slave link
);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              parity_err_q;
    logic              frame_err_q;
    logic              busy_q;
    logic              acc_clr;
    logic              acc_en;
    logic              acc_q;
    logic              last_bit;

    assign last_bit = (cnt == CNT_W'(DATA_W - 1));

    parity_acc u_parity_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (link.sin),
        .q   (acc_q)
    );

    // Next-state and parity accumulator controls; nothing moves without bit_en
    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        if (link.bit_en) begin
            case (state)
                ST_IDLE: begin
                    if (link.sin == START_BIT) begin
                        state_nxt = ST_DATA;
                        acc_clr   = 1'b1;
                    end
                end
                ST_DATA: begin
                    acc_en = 1'b1;
                    if (last_bit) begin
                        state_nxt = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    acc_en    = 1'b1;
                    state_nxt = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt = (link.sin == STOP_BIT) ? ST_IDLE : ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    if (link.sin) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs; pulses default low every clock
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            shreg        <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy_q      <= (state_nxt != ST_IDLE);
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (link.bit_en) begin
                case (state)
                    ST_IDLE: begin
                        if (link.sin == START_BIT) begin
                            cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg <= {link.sin, shreg[DATA_W-1:1]};
                        cnt   <= cnt + 1'b1;
                    end
                    ST_STOP: begin
                        if (link.sin == STOP_BIT) begin
                            rx_data_q    <= shreg;
                            rx_valid_q   <= 1'b1;
                            parity_err_q <= parity_fail(acc_q, PARITY_ODD);
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign link.rx_data    = rx_data_q;
    assign link.rx_valid   = rx_valid_q;
    assign link.parity_err = parity_err_q;
    assign link.frame_err  = frame_err_q;
    assign link.busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: even and odd parity instances fed the same line.
module tb_serial_parity_rx;

    logic clk = 1'b0;
    logic rst;
    logic bit_en;
    logic sin;

    always #5 clk = ~clk;

    serial_parity_rx_if #(.DATA_W(8)) lk ();
    serial_parity_rx_if #(.DATA_W(8)) lk_odd ();

    assign lk.bit_en     = bit_en;
    assign lk.sin        = sin;
    assign lk_odd.bit_en = bit_en;
    assign lk_odd.sin    = sin;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .link (lk.slave)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_dut_odd (
        .clk  (clk),
        .rst  (rst),
        .link (lk_odd.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor on the even instance, sampled mid-cycle
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         width_bad = 0;
    logic       prev_v = 1'b0;
    int         valid_cyc[$];
    logic [7:0] valid_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lk.rx_valid) begin
            n_valid++;
            valid_cyc.push_back(cyc);
            valid_data.push_back(lk.rx_data);
        end
        if (lk.frame_err) n_ferr++;
        if (lk.rx_valid && prev_v) width_bad++;
        prev_v = lk.rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One line bit; bit_en is high for exactly one edge, then gap idle clocks
    task automatic send_bit(input logic b, input int gap);
        sin    = b;
        bit_en = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(par, gap);
        send_bit(stop, gap);
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int v0, f0, q0;

    initial begin
        rst    = 1'b1;
        bit_en = 1'b0;
        sin    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset_rx_data",    lk.rx_data,    0);
        chk("reset_rx_valid",   lk.rx_valid,   0);
        chk("reset_parity_err", lk.parity_err, 0);
        chk("reset_frame_err",  lk.frame_err,  0);
        chk("reset_busy",       lk.busy,       0);

        // Good frame 0xA5, even parity bit 0
        v0 = n_valid;
        send_bit(1'b0, 0);
        chk("good_busy_after_start", lk.busy, 1);
        for (int i = 0; i < 8; i++) send_bit(i[0] ? (8'hA5 >> i) & 1 : (8'hA5 >> i) & 1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        chk("good_rx_valid",   lk.rx_valid,   1);
        chk("good_rx_data",    lk.rx_data,    8'hA5);
        chk("good_parity_err", lk.parity_err, 0);
        chk("good_frame_err",  lk.frame_err,  0);
        chk("good_busy_falls", lk.busy,       0);
        idle(1);
        chk("good_valid_one_cycle", lk.rx_valid, 0);
        idle(2);
        chk("good_pulse_count", n_valid - v0, 1);

        // Bad parity: same data, parity bit 1
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        chk("badpar_rx_valid",   lk.rx_valid,   1);
        chk("badpar_rx_data",    lk.rx_data,    8'hA5);
        chk("badpar_parity_err", lk.parity_err, 1);
        idle(3);
        chk("badpar_err_held", lk.parity_err, 1);

        // 0x01 with parity bit 0: good for odd, bad for even
        send_frame(8'h01, 1'b0, 1'b1, 0);
        chk("odd_rx_valid",    lk_odd.rx_valid,   1);
        chk("odd_rx_data",     lk_odd.rx_data,    8'h01);
        chk("odd_parity_err",  lk_odd.parity_err, 0);
        chk("even_parity_err", lk.parity_err,     1);
        idle(3);

        // Framing error, then a 5-bit break, then release
        v0 = n_valid;
        f0 = n_ferr;
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        chk("ferr_pulse",      lk.frame_err,  1);
        chk("ferr_no_valid",   lk.rx_valid,   0);
        chk("ferr_busy",       lk.busy,       1);
        chk("ferr_data_held",  lk.rx_data,    8'h01);
        chk("ferr_par_held",   lk.parity_err, 1);
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0, 0);
            chk("break_busy", lk.busy, 1);
        end
        send_bit(1'b1, 0);
        chk("release_busy", lk.busy, 0);
        idle(4);
        chk("break_no_valid",   n_valid - v0, 0);
        chk("break_ferr_count", n_ferr - f0, 1);
        chk("break_data_held",  lk.rx_data, 8'h01);

        // Throttled back-to-back: bit_en every 3rd clock
        q0 = valid_cyc.size();
        width_bad = 0;
        send_frame(8'h3C, 1'b0, 1'b1, 2);
        send_frame(8'hC3, 1'b0, 1'b1, 2);
        idle(5);
        chk("b2b_pulse_count", valid_cyc.size() - q0, 2);
        if (valid_cyc.size() - q0 == 2) begin
            chk("b2b_spacing", valid_cyc[q0+1] - valid_cyc[q0], 33);
            chk("b2b_data0",   valid_data[q0],   8'h3C);
            chk("b2b_data1",   valid_data[q0+1], 8'hC3);
        end
        chk("b2b_pulse_width", width_bad, 0);
        chk("b2b_parity_err",  lk.parity_err, 0);

        // Reset after 4 data bits, then a clean 0x5A
        v0 = n_valid;
        f0 = n_ferr;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rx_data",    lk.rx_data,    0);
        chk("rst_rx_valid",   lk.rx_valid,   0);
        chk("rst_parity_err", lk.parity_err, 0);
        chk("rst_frame_err",  lk.frame_err,  0);
        chk("rst_busy",       lk.busy,       0);
        idle(2);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        chk("post_rst_valid", lk.rx_valid, 1);
        chk("post_rst_data",  lk.rx_data,  8'h5A);
        idle(3);
        chk("post_rst_valid_count", n_valid - v0, 1);
        chk("post_rst_ferr_count",  n_ferr - f0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Bit-serial frame receiver with XOR parity checking. It is the receiving end of the lab's parity-protected serial link: the transmitter appends an XOR-computed parity bit, and this block deserializes the frame, recomputes the XOR, and flags mismatches. It sits between the link pin `sin` and any consumer of parallel data words.

## Interface
- `DATA_W`, default 8: data bits per frame (2..16).
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk`: input, 1 bit. Single clock; all logic is on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `bit_en`: input, 1 bit. Line-rate strobe. `sin` is sampled only on cycles where `bit_en`=1.
- `sin`: input, 1 bit. Serial line; idle level is 1.
- `rx_data`: output, `DATA_W` bits. Last frame whose stop bit was valid.
- `rx_valid`: output, 1 bit. One-cycle pulse when a frame completes with a good stop bit.
- `parity_err`: output, 1 bit. Parity result of the frame reported by `rx_valid`; held until the next `rx_valid`.
- `frame_err`: output, 1 bit. One-cycle pulse when the stop bit is sampled as 0.
- `busy`: output, 1 bit. High whenever the state is not IDLE.

## Operation
- Frame format, in line order: start (0), `DATA_W` data bits LSB first, parity bit, stop (1).
- Parity rule: the XOR of all data bits, the parity bit and `PARITY_ODD` must equal 0. Any other result sets `parity_err`=1.
- States:
  - IDLE: on `bit_en` with `sin`=0, clear the bit count and the running XOR, then go to DATA.
  - DATA: on each `bit_en`, right-shift `sin` into the MSB of the shift register, XOR it into the running parity, and increment the count. After bit `DATA_W`-1, go to PARITY.
  - PARITY: on `bit_en`, fold `sin` into the running XOR, then go to STOP.
  - STOP: on `bit_en`:
    - `sin`=1: load `rx_data` from the shift register, pulse `rx_valid`, load `parity_err`, go to IDLE.
    - `sin`=0: pulse `frame_err`. `rx_data` and `parity_err` are unchanged. Go to WAIT_HIGH.
  - WAIT_HIGH: on `bit_en` with `sin`=1, go to IDLE. A line held low, such as a break, never starts a false frame.
- When `bit_en`=0, the state, count, shift register and XOR all hold. Pulses are never generated on cycles where `bit_en`=0.
- Back-to-back frames are supported. A start bit sampled on the `bit_en` immediately after the stop bit begins the next frame with no idle bit required.
- Reset values: state IDLE, `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, count 0, XOR 0.
- Reset mid-frame abandons the partial frame. No pulse is emitted.

## Timing
- All outputs are registered.
- `rx_valid` and `frame_err` go high in the cycle after the clock edge on which the stop bit is sampled, and last exactly one `clk` cycle regardless of the `bit_en` rate.
- Latency from the start-bit sample to `rx_valid` is `DATA_W`+2 further `bit_en` strobes, plus one registered edge.
- `busy` rises in the cycle after the start-bit sample. It falls in the same cycle that `rx_valid` rises, or in the cycle after the release sample in WAIT_HIGH.
- With `bit_en` tied high, one frame occupies `DATA_W`+3 clocks.

## Structure
- State encodings (IDLE, DATA, PARITY, STOP, WAIT_HIGH) go in a shared include `serial_link_defs.vh`, together with the frame constants START_BIT=0 and STOP_BIT=1, so the transmitter uses the same values.
- One sub-module is natural: `parity_acc`, a 1-bit running-XOR register with clear and enable inputs. The transmitter reuses it.
- Everything else is a single FSM, a count register and a shift register. Target 150–250 lines.

## Test plan
- Good frame: `bit_en`=1; `sin` = 0, 1,0,1,0,0,1,0,1, 0, 1, which is 0xA5 with even parity 0. Expect `rx_data`=8'hA5, one `rx_valid` pulse, `parity_err`=0 and `frame_err`=0.
- Bad parity: the same frame with the parity bit set to 1. Expect `rx_data`=8'hA5, `rx_valid` pulse, `parity_err`=1.
- Odd parity: `PARITY_ODD`=1, data 0x01, parity bit 0. Expect `parity_err`=0.
- Framing error: 0xA5 with stop bit 0, then `sin` held at 0 for 5 bits, then 1. Expect:
  - a `frame_err` pulse and no `rx_valid`;
  - `rx_data` keeps its previous value;
  - `busy` stays high until the 1 is sampled;
  - no new frame starts during the low period.
- Throttled back-to-back: `bit_en` high every 3rd cycle; 0x3C is immediately followed by 0xC3. Expect two `rx_valid` pulses, 33 clocks apart, each one cycle wide, with the correct data.
- Reset mid-frame: assert `rst` after 4 data bits, then send a good 0x5A frame. Expect:
  - all outputs read 0 after the reset;
  - the first post-reset `rx_valid` carries 8'h5A;
  - no spurious pulse.
